sram_delay_line: RTL and testbench
==================================

# sram_delay_line

Circular delay-line sequencer that sits directly upstream of `sram_controller` and is its only master. Each accepted input sample causes a read of the oldest stored sample at the current pointer, then a write of the new sample to that same address. The pointer advances with wrap-around, so the output stream is the input stream delayed by exactly DEPTH samples. Until the buffer has been filled once, stale SRAM contents are masked to zero.

## Interface
- `DEPTH`, 650: number of delay slots; SRAM addresses 0..DEPTH-1 are used; legal range 2..1024.
- `ADDR_W`, 10: SRAM address width.
- `DATA_W`, 8: sample width.

- `clk`  in  1  single system clock; all state updates on rising edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `clear`  in  1  synchronous; restarts the delay line.
- `in_valid`  in  1  upstream sample present.
- `in_data`  in  DATA_W  upstream sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `out_valid`  out  1  delayed sample present.
- `out_data`  out  DATA_W  delayed sample.
- `out_ready`  in  1  downstream accepts `out_data`.
- `r_en`  out  1  SRAM read enable, to `sram_controller.r_en`.
- `w_en`  out  1  SRAM write enable, to `sram_controller.w_en`.
- `address`  out  ADDR_W  SRAM address, to `sram_controller.address`.
- `write_data`  out  DATA_W  to `sram_controller.write_data`.
- `read_data`  in  DATA_W  from `sram_controller.read_data`; valid in the cycle after the `r_en` cycle.

## Operation
- Registers:
  - `state` ∈ {IDLE, READ, WRITE, OUT}
  - `ptr` [ADDR_W]
  - `primed` (1 bit)
  - `samp` [DATA_W], latched input
  - `out_data` register
- Decoded outputs:
  - `in_ready` = (state==IDLE) && !clear.
  - `r_en` = (state==READ).
  - `w_en` = (state==WRITE).
  - `out_valid` = (state==OUT).
  - `address` = `ptr` at all times.
  - `write_data` = `samp`.
- FSM:
  - IDLE: on `in_valid && in_ready`, latch `samp` ← `in_data` and go to READ; otherwise stay.
  - READ: drive `r_en` for one cycle, then go to WRITE.
  - WRITE: drive `w_en` for one cycle. At the end of this cycle, `out_data` ← `primed ? read_data : 0`. Then go to OUT.
  - OUT: hold `out_valid` and `out_data` stable until `out_ready`. On handshake:
    - `ptr` ← (`ptr`==DEPTH-1) ? 0 : `ptr`+1.
    - If `ptr`==DEPTH-1, set `primed` ← 1.
    - Go to IDLE.
- `r_en` and `w_en` are never high in the same cycle.
- SRAM is idle in IDLE and OUT.
- `primed`, once set, stays set until `clear` or reset.
- `clear` has priority over every other event:
  - Next state is IDLE; `ptr` ← 0, `primed` ← 0, `out_data` ← 0.
  - An in-flight sample is discarded and no `out_valid` is produced for it.
  - If `clear` arrives in the WRITE cycle, that write still lands, because `w_en` is already asserted.
  - `clear` does not zero SRAM contents; the `primed` mask makes stale contents invisible.
- Reset (`n_rst`=0, asynchronous): state IDLE, `ptr` 0, `primed` 0, `samp` 0, `out_data` 0.
  - Outputs during reset: `r_en`=0, `w_en`=0, `out_valid`=0, `address`=0, `write_data`=0, `in_ready`=1 (if `clear`=0).
  - Reset mid-transaction aborts immediately with no further SRAM access.

## Timing
- Sample accepted at edge E0 (IDLE):
  - READ in cycle E0..E1.
  - WRITE in cycle E1..E2; `read_data` is captured at E2.
  - `out_valid` is high from E2.
- Latency from input handshake to `out_valid`: 2 cycles.
- Minimum period: 4 cycles per sample (IDLE, READ, WRITE, OUT), i.e. one sample per 4 clocks with `out_ready` tied high.
- Backpressure: `out_ready`=0 holds OUT indefinitely with `in_ready`=0 and no SRAM activity.
- Wrap: after the handshake for the sample at `ptr`=DEPTH-1, `ptr` becomes 0 and `primed` becomes 1. Sample k (0-based) is output as sample k+DEPTH.

## Test plan
- Reset check: assert `n_rst`=0 mid-READ → `r_en`, `w_en`, `out_valid`, `address`, `out_data` all 0 and `in_ready`=1 within the same timestep; no SRAM write occurs.
- First sample, DEPTH=650: `in_data`=15 → `r_en`@addr 0, then `w_en`@addr 0 with `write_data`=15, `out_valid` with `out_data`=0, then `address`=1.
- Wrap/delay with DEPTH=4 override: feed 1,2,3,4,5,6 → `out_data` 0,0,0,0,1,2; addresses 0,1,2,3,0,1; `primed` rises after the 4th handshake.
- Backpressure: hold `out_ready`=0 for 5 cycles in OUT with `in_valid`=1 → `out_valid` and `out_data` stable, `in_ready`=0, `r_en`=`w_en`=0; release → exactly one handshake, then IDLE.
- Clear: DEPTH=4, feed 1..5, assert `clear` during the READ of sample 6 → no `out_valid` for sample 6. Then feed 9 → write@addr 0 and `out_data`=0.
- Default wrap at DEPTH=650: feed 651 samples with value = index mod 256 → sample 650 reads addr 0, outputs 0 (the value of sample 0), and the 650th handshake sets `ptr` from 649 to 0.

Source files
------------

// File: rtl/sram_delay_line_if.sv
// sram_delay_line_if: sample stream in/out plus the SRAM controller bus.
// slave is the delay line, master is its environment.
interface sram_delay_line_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              r_en;
   logic              w_en;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;

   modport slave (
      input  in_valid, in_data, out_ready, read_data,
      output in_ready, out_valid, out_data,
      output r_en, w_en, address, write_data
   );

   modport master (
      output in_valid, in_data, out_ready, read_data,
      input  in_ready, out_valid, out_data,
      input  r_en, w_en, address, write_data
   );
endinterface

// File: rtl/sram_delay_line.sv
// sram_delay_line: circular delay line, one SRAM read then write per
// sample; output is the input delayed by DEPTH samples.
module sram_delay_line #(
   parameter int DEPTH  = 650,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input logic              clk,
   input logic              n_rst,
   input logic              clear,
   sram_delay_line_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      OUT
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic              primed;
   logic [DATA_W-1:0] samp;
   logic [DATA_W-1:0] out_q;

   assign bus.in_ready   = (state == IDLE) && !clear;
   assign bus.r_en       = (state == READ);
   assign bus.w_en       = (state == WRITE);
   assign bus.out_valid  = (state == OUT);
   assign bus.out_data   = out_q;
   assign bus.address    = ptr;
   assign bus.write_data = samp;

   // sequencer: accept, read oldest, overwrite, present, advance pointer
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         ptr    <= '0;
         primed <= 1'b0;
         samp   <= '0;
         out_q  <= '0;
      end else if (clear) begin
         state  <= IDLE;
         ptr    <= '0;
         primed <= 1'b0;
         out_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  samp  <= bus.in_data;
                  state <= READ;
               end
            end
            READ: begin
               state <= WRITE;
            end
            WRITE: begin
               out_q <= primed ? bus.read_data : '0;
               state <= OUT;
            end
            OUT: begin
               if (bus.out_ready) begin
                  if (ptr == LAST) begin
                     ptr    <= '0;
                     primed <= 1'b1;
                  end else begin
                     ptr <= ptr + ADDR_W'(1);
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_delay_line.sv
// tb_sram_delay_line: DEPTH=4 and DEPTH=650 instances on behavioural
// SRAMs, checked against tables and a queue-based delay model.
module tb_sram_delay_line;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   sram_delay_line_if #(.ADDR_W(10), .DATA_W(8)) i4 ();
   sram_delay_line_if #(.ADDR_W(10), .DATA_W(8)) i650 ();

   logic       clr [2];
   logic       iv [2];
   logic [7:0] id [2];
   logic       ordy [2];

   logic       ir [2];
   logic       ov [2];
   logic       re [2];
   logic       we [2];
   logic [7:0] od [2];
   logic [7:0] wd [2];
   logic [9:0] ad [2];

   sram_delay_line #(.DEPTH(4), .ADDR_W(10), .DATA_W(8)) u4 (
      .clk(clk), .n_rst(n_rst), .clear(clr[0]), .bus(i4)
   );
   sram_delay_line #(.DEPTH(650), .ADDR_W(10), .DATA_W(8)) u650 (
      .clk(clk), .n_rst(n_rst), .clear(clr[1]), .bus(i650)
   );

   assign i4.in_valid    = iv[0];
   assign i4.in_data     = id[0];
   assign i4.out_ready   = ordy[0];
   assign i650.in_valid  = iv[1];
   assign i650.in_data   = id[1];
   assign i650.out_ready = ordy[1];

   assign ir[0] = i4.in_ready;   assign ir[1] = i650.in_ready;
   assign ov[0] = i4.out_valid;  assign ov[1] = i650.out_valid;
   assign re[0] = i4.r_en;       assign re[1] = i650.r_en;
   assign we[0] = i4.w_en;       assign we[1] = i650.w_en;
   assign od[0] = i4.out_data;   assign od[1] = i650.out_data;
   assign wd[0] = i4.write_data; assign wd[1] = i650.write_data;
   assign ad[0] = i4.address;    assign ad[1] = i650.address;

   // behavioural SRAMs, pre-filled with garbage so masking is visible
   logic [7:0] mem0 [1024];
   logic [7:0] mem1 [1024];
   int wcnt0 = 0;
   int wcnt1 = 0;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem0[i] = 8'($urandom_range(1, 255));
         mem1[i] = 8'($urandom_range(1, 255));
      end
   end

   always @(posedge clk) begin
      if (i4.r_en) i4.read_data <= mem0[i4.address];
      if (i4.w_en) begin
         mem0[i4.address] <= i4.write_data;
         wcnt0 <= wcnt0 + 1;
      end
   end

   always @(posedge clk) begin
      if (i650.r_en) i650.read_data <= mem1[i650.address];
      if (i650.w_en) begin
         mem1[i650.address] <= i650.write_data;
         wcnt1 <= wcnt1 + 1;
      end
   end

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // strobes must be mutually exclusive on every cycle
   always @(negedge clk) begin
      if (n_rst) begin
         for (int s = 0; s < 2; s++) begin
            checks++;
            if (re[s] && we[s]) begin
               errors++;
               $display("FAIL rw_excl[%0d]: got r_en=1 w_en=1", s);
            end
         end
      end
   end

   // reference model: inputs accepted since the last clear/reset
   logic [7:0] h0 [$];
   logic [7:0] h1 [$];

   function automatic int dep_of(input int s);
      return (s == 0) ? 4 : 650;
   endfunction

   function automatic void model_clear(input int s);
      if (s == 0) h0.delete();
      else h1.delete();
   endfunction

   function automatic void model_push(input int s, input logic [7:0] d,
                                      output logic [7:0] eo,
                                      output logic [9:0] ea);
      int n;
      int dp;
      dp = dep_of(s);
      n = (s == 0) ? h0.size() : h1.size();
      ea = 10'(n % dp);
      if (n >= dp) eo = (s == 0) ? h0[n - dp] : h1[n - dp];
      else eo = 8'd0;
      if (s == 0) h0.push_back(d);
      else h1.push_back(d);
   endfunction

   // one full sample transaction with phase-by-phase checks
   task automatic do_sample(input int s, input logic [7:0] d,
                            input logic [7:0] eo, input logic [9:0] ea,
                            input int hold, input string tag);
      int n;
      logic [9:0] en;
      en = (int'(ea) == dep_of(s) - 1) ? 10'd0 : ea + 10'd1;
      @(negedge clk);
      iv[s] = 1'b1;
      id[s] = d;
      ordy[s] = 1'b1;
      n = 0;
      while (!ir[s] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         chk({tag, "_in_ready_timeout"}, 0, 1);
         iv[s] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      iv[s] = 1'b0;
      chk({tag, "_read_en"}, int'(re[s]), 1);
      chk({tag, "_read_addr"}, int'(ad[s]), int'(ea));
      @(posedge clk); #1;
      ordy[s] = (hold == 0);
      chk({tag, "_write_en"}, int'(we[s]), 1);
      chk({tag, "_write_addr"}, int'(ad[s]), int'(ea));
      chk({tag, "_write_data"}, int'(wd[s]), int'(d));
      @(posedge clk); #1;
      chk({tag, "_out_valid"}, int'(ov[s]), 1);
      chk({tag, "_out_data"}, int'(od[s]), int'(eo));
      for (int k = 0; k < hold; k++) begin
         iv[s] = 1'b1;
         @(posedge clk); #1;
         chk({tag, "_bp_valid"}, int'(ov[s]), 1);
         chk({tag, "_bp_data"}, int'(od[s]), int'(eo));
         chk({tag, "_bp_in_ready"}, int'(ir[s]), 0);
         chk({tag, "_bp_sram_idle"}, int'(re[s] | we[s]), 0);
         chk({tag, "_bp_addr"}, int'(ad[s]), int'(ea));
      end
      iv[s] = 1'b0;
      ordy[s] = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_done_valid"}, int'(ov[s]), 0);
      chk({tag, "_next_addr"}, int'(ad[s]), int'(en));
      chk({tag, "_idle_ready"}, int'(ir[s]), 1);
   endtask

   task automatic model_sample(input int s, input logic [7:0] d,
                               input int hold, input string tag);
      logic [7:0] eo;
      logic [9:0] ea;
      model_push(s, d, eo, ea);
      do_sample(s, d, eo, ea, hold, tag);
   endtask

   task automatic do_clear(input int s);
      @(negedge clk);
      clr[s] = 1'b1;
      #1;
      chk("clear_in_ready", int'(ir[s]), 0);
      @(negedge clk);
      clr[s] = 1'b0;
      model_clear(s);
   endtask

   typedef struct {
      logic [7:0] din;
      logic [7:0] eout;
      logic [9:0] eaddr;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [7:0] eo;
      logic [9:0] ea;
      int wc;
      int seen;

      tbl[0] = '{8'd1, 8'd0, 10'd0};
      tbl[1] = '{8'd2, 8'd0, 10'd1};
      tbl[2] = '{8'd3, 8'd0, 10'd2};
      tbl[3] = '{8'd4, 8'd0, 10'd3};
      tbl[4] = '{8'd5, 8'd1, 10'd0};
      tbl[5] = '{8'd6, 8'd2, 10'd1};

      for (int s = 0; s < 2; s++) begin
         clr[s] = 1'b0;
         iv[s] = 1'b0;
         id[s] = 8'd0;
         ordy[s] = 1'b1;
      end

      #12;
      chk("rst_in_ready", int'(ir[0]), 1);
      chk("rst_out_valid", int'(ov[0]), 0);
      chk("rst_r_en", int'(re[0]), 0);
      chk("rst_w_en", int'(we[0]), 0);
      chk("rst_address", int'(ad[0]), 0);
      chk("rst_write_data", int'(wd[0]), 0);
      @(negedge clk);
      n_rst = 1'b1;

      // DEPTH=4 wrap table
      for (int i = 0; i < 6; i++)
         do_sample(0, tbl[i].din, tbl[i].eout, tbl[i].eaddr, 0, "wrap4");

      // clear during READ of sample 6
      do_clear(0);
      for (int i = 1; i <= 5; i++) model_sample(0, 8'(i), 0, "clr_pre");
      @(negedge clk);
      iv[0] = 1'b1;
      id[0] = 8'd6;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      chk("clr_read_en", int'(re[0]), 1);
      clr[0] = 1'b1;
      @(posedge clk); #1;
      clr[0] = 1'b0;
      chk("clr_no_write", int'(we[0]), 0);
      chk("clr_addr", int'(ad[0]), 0);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (ov[0]) seen++;
         @(posedge clk); #1;
      end
      chk("clr_no_out_valid", seen, 0);
      model_clear(0);
      do_sample(0, 8'd9, 8'd0, 10'd0, 0, "clr_after");
      model_push(0, 8'd9, eo, ea);

      // backpressure with in_valid held high
      model_sample(0, 8'd33, 5, "bp");

      // randomized traffic against the model
      for (int i = 0; i < 40; i++) begin
         if (i == 20) do_clear(0);
         model_sample(0, 8'($urandom), $urandom_range(0, 2), "rand4");
      end

      // reset mid-READ
      @(negedge clk);
      iv[0] = 1'b1;
      id[0] = 8'd77;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      chk("rst_mid_read_en", int'(re[0]), 1);
      wc = wcnt0;
      n_rst = 1'b0;
      #1;
      chk("rstm_r_en", int'(re[0]), 0);
      chk("rstm_w_en", int'(we[0]), 0);
      chk("rstm_out_valid", int'(ov[0]), 0);
      chk("rstm_address", int'(ad[0]), 0);
      chk("rstm_out_data", int'(od[0]), 0);
      chk("rstm_in_ready", int'(ir[0]), 1);
      @(posedge clk);
      @(posedge clk); #1;
      chk("rstm_no_write", wcnt0, wc);
      @(negedge clk);
      n_rst = 1'b1;
      model_clear(0);
      model_clear(1);

      // DEPTH=650 first sample
      do_sample(1, 8'd15, 8'd0, 10'd0, 0, "first650");
      do_clear(1);

      // DEPTH=650 full wrap
      for (int i = 0; i < 651; i++) begin
         if (i == 650) begin
            model_push(1, 8'(i % 256), eo, ea);
            do_sample(1, 8'(i % 256), 8'd0, 10'd0, 0, "wrap650_last");
         end else begin
            model_sample(1, 8'(i % 256), 0, "wrap650");
         end
      end
      model_sample(1, 8'd200, 0, "wrap650_post");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
